ad_ip_jesd204_tpl_adc_sync_ctrl: RTL and testbench

AD_IP_JESD204_TPL_ADC_SYNC_CTRL -- requirements
Module: ad_ip_jesd204_tpl_adc_sync_ctrl

---
 rtl/ad_ip_jesd204_tpl_adc_sync_ctrl.sv | 175 +++++++++++++++++
 tb/tb_ad_ip_jesd204_tpl_adc_sync_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_sync_ctrl.sv
// ADC sync controller: arm/disarm FSM, external sync edge detect, period measure.
// Define ADC_SYNC_TIMEOUT_EN to build the armed/measure wait timeout.
module ad_ip_jesd204_tpl_adc_sync_ctrl #(
    parameter int NUM_CHANNELS  = 1,
    parameter int COUNTER_WIDTH = 32,
    parameter int SYNC_EDGE     = 0,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     adc_sync,
    input  logic                     adc_sync_disarm,
    input  logic                     sync_mode,
    input  logic                     adc_external_sync,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
    input  logic                     link_valid,
    input  logic [NUM_CHANNELS-1:0]  channel_enable,
    output logic [NUM_CHANNELS-1:0]  adc_valid,
    output logic                     adc_sync_status,
    output logic                     adc_rst_sync,
    output logic                     sync_pulse,
    output logic [1:0]               fsm_state,
    output logic [COUNTER_WIDTH-1:0] period_count,
    output logic                     period_valid,
    output logic [15:0]              sync_event_count,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ARMED   = 2'b01,
        MEASURE = 2'b10,
        DONE    = 2'b11
    } state_t;

    // Falling-edge mode idles the synchronizer high so reset creates no edge.
    localparam logic SYNC_INIT = (SYNC_EDGE == 1);

    state_t state;
    state_t state_nxt;

    logic s1;
    logic s2;
    logic s3;
    logic edge_det;
    logic active;
    logic edge_acc;
    logic arm_acc;
    logic meas_edge;
    logic timeout_hit;

    logic [COUNTER_WIDTH-1:0] period_cnt;
    logic [COUNTER_WIDTH-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= SYNC_INIT;
            s2 <= SYNC_INIT;
            s3 <= SYNC_INIT;
        end else begin
            s1 <= adc_external_sync;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_comb begin
        edge_det = s2 ^ s3;
        if (SYNC_EDGE == 0) begin
            edge_det = s2 & ~s3;
        end else if (SYNC_EDGE == 1) begin
            edge_det = ~s2 & s3;
        end
    end

    assign active    = (state == ARMED) || (state == MEASURE);
    assign edge_acc  = edge_det & active & ~adc_sync_disarm;
    assign arm_acc   = adc_sync & ~active & ~adc_sync_disarm;
    assign meas_edge = edge_acc & (state == MEASURE);
    assign cnt_inc   = (&period_cnt) ? period_cnt : period_cnt + 1'b1;

`ifdef ADC_SYNC_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wait_cnt;

    // An edge in the same cycle wins over the timeout.
    assign timeout_hit = active && !edge_det && (timeout_limit != '0) &&
                         (({1'b0, wait_cnt} + 1'b1) == {1'b0, timeout_limit});

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!active || edge_acc) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (arm_acc) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit && !adc_sync_disarm) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^timeout_limit;
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        if (adc_sync_disarm) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (adc_sync) state_nxt = ARMED;
                end
                ARMED: begin
                    if (edge_det) begin
                        state_nxt = sync_mode ? MEASURE : DONE;
                    end else if (timeout_hit) begin
                        state_nxt = IDLE;
                    end
                end
                MEASURE: begin
                    if (!edge_det && timeout_hit) state_nxt = IDLE;
                end
                DONE: begin
                    if (adc_sync) state_nxt = ARMED;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            adc_sync_status  <= 1'b0;
            adc_rst_sync     <= 1'b0;
            sync_pulse       <= 1'b0;
            period_valid     <= 1'b0;
            period_count     <= '0;
            period_cnt       <= '0;
            sync_event_count <= '0;
        end else begin
            state           <= state_nxt;
            adc_sync_status <= (state_nxt == ARMED);
            adc_rst_sync    <= (state_nxt == ARMED);
            sync_pulse      <= edge_det;
            period_valid    <= meas_edge;
            if (meas_edge) begin
                period_count <= cnt_inc;
            end
            if (state == MEASURE && state_nxt == MEASURE && !edge_acc) begin
                period_cnt <= cnt_inc;
            end else begin
                period_cnt <= '0;
            end
            if (edge_acc) begin
                sync_event_count <= sync_event_count + 16'd1;
            end
        end
    end

    assign fsm_state = state;
    assign adc_valid = channel_enable &
                       {NUM_CHANNELS{link_valid & (state != ARMED)}};

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_sync_ctrl.sv
// Bench for ad_ip_jesd204_tpl_adc_sync_ctrl: default, 4-bit counter and both-edge builds.
module tb_ad_ip_jesd204_tpl_adc_sync_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        adc_sync;
    logic        adc_sync_disarm;
    logic        sync_mode;
    logic        ext;
    logic [23:0] timeout_limit;
    logic        link_valid;
    logic [1:0]  channel_enable;

    logic [1:0]  adc_valid;
    logic        status;
    logic        rst_sync;
    logic        sync_pulse;
    logic [1:0]  fsm_state;
    logic [31:0] period_count;
    logic        period_valid;
    logic [15:0] evc;
    logic        timeout_err;

    logic [0:0]  sat_adc_valid;
    logic        sat_status;
    logic        sat_rst_sync;
    logic        sat_sync_pulse;
    logic [1:0]  sat_fsm;
    logic [3:0]  sat_period_count;
    logic        sat_period_valid;
    logic [15:0] sat_evc;
    logic        sat_timeout_err;

    logic [0:0]  both_adc_valid;
    logic        both_status;
    logic        both_rst_sync;
    logic        both_sync_pulse;
    logic [1:0]  both_fsm;
    logic [31:0] both_period_count;
    logic        both_period_valid;
    logic [15:0] both_evc;
    logic        both_timeout_err;

    ad_ip_jesd204_tpl_adc_sync_ctrl #(.NUM_CHANNELS(2)) dut (
        .clk(clk), .reset(reset), .adc_sync(adc_sync),
        .adc_sync_disarm(adc_sync_disarm), .sync_mode(sync_mode),
        .adc_external_sync(ext), .timeout_limit(timeout_limit),
        .link_valid(link_valid), .channel_enable(channel_enable),
        .adc_valid(adc_valid), .adc_sync_status(status),
        .adc_rst_sync(rst_sync), .sync_pulse(sync_pulse),
        .fsm_state(fsm_state), .period_count(period_count),
        .period_valid(period_valid), .sync_event_count(evc),
        .timeout_err(timeout_err)
    );

    ad_ip_jesd204_tpl_adc_sync_ctrl #(.COUNTER_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset), .adc_sync(adc_sync),
        .adc_sync_disarm(adc_sync_disarm), .sync_mode(sync_mode),
        .adc_external_sync(ext), .timeout_limit(timeout_limit),
        .link_valid(link_valid), .channel_enable(channel_enable[0:0]),
        .adc_valid(sat_adc_valid), .adc_sync_status(sat_status),
        .adc_rst_sync(sat_rst_sync), .sync_pulse(sat_sync_pulse),
        .fsm_state(sat_fsm), .period_count(sat_period_count),
        .period_valid(sat_period_valid), .sync_event_count(sat_evc),
        .timeout_err(sat_timeout_err)
    );

    ad_ip_jesd204_tpl_adc_sync_ctrl #(.SYNC_EDGE(2)) dut_both (
        .clk(clk), .reset(reset), .adc_sync(adc_sync),
        .adc_sync_disarm(adc_sync_disarm), .sync_mode(sync_mode),
        .adc_external_sync(ext), .timeout_limit(timeout_limit),
        .link_valid(link_valid), .channel_enable(channel_enable[0:0]),
        .adc_valid(both_adc_valid), .adc_sync_status(both_status),
        .adc_rst_sync(both_rst_sync), .sync_pulse(both_sync_pulse),
        .fsm_state(both_fsm), .period_count(both_period_count),
        .period_valid(both_period_valid), .sync_event_count(both_evc),
        .timeout_err(both_timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    int pulse_q[$];
    int period_q[$];
    int both_stamps[$];
    int exp_c;
    int exp_p;

    typedef struct {
        logic       armed;
        logic       link;
        logic [1:0] en;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[7];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none at cycle %0d", name, cyc);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_sync();
        adc_sync = 1'b1;
        tick();
        adc_sync = 1'b0;
    endtask

    task automatic pulse_disarm();
        adc_sync_disarm = 1'b1;
        tick();
        adc_sync_disarm = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    // Rising input driven now is first sampled next edge; pulse shows 3 edges on.
    task automatic set_ext(input logic v);
        if (v && !ext) pulse_q.push_back(cyc + 3);
        ext = v;
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sync_pulse === 1'b1) begin
                if (pulse_q.size() == 0) begin
                    fail("sync_pulse_unexpected");
                end else begin
                    exp_c = pulse_q.pop_front();
                    check("sync_pulse_cycle", 32'(cyc), 32'(exp_c));
                end
            end
            if (period_valid === 1'b1) begin
                if (period_q.size() == 0) begin
                    fail("period_valid_unexpected");
                end else begin
                    exp_p = period_q.pop_front();
                    check("period_count", period_count, 32'(exp_p));
                end
            end
            if (both_sync_pulse === 1'b1) both_stamps.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 2'b11, 2'b11};
        vecs[1] = '{1'b0, 1'b0, 2'b11, 2'b00};
        vecs[2] = '{1'b0, 1'b1, 2'b01, 2'b01};
        vecs[3] = '{1'b0, 1'b1, 2'b10, 2'b10};
        vecs[4] = '{1'b1, 1'b1, 2'b11, 2'b00};
        vecs[5] = '{1'b1, 1'b1, 2'b01, 2'b00};
        vecs[6] = '{1'b1, 1'b0, 2'b11, 2'b00};

        reset = 1'b1;
        adc_sync = 1'b0;
        adc_sync_disarm = 1'b0;
        sync_mode = 1'b0;
        ext = 1'b0;
        timeout_limit = '0;
        link_valid = 1'b0;
        channel_enable = '0;
        tick(3);
        mon_en = 1'b1;

        check("rst_fsm", 32'(fsm_state), 32'd0);
        check("rst_period", period_count, 32'd0);
        check("rst_evc", 32'(evc), 32'd0);
        check("rst_pvalid", 32'(period_valid), 32'd0);
        check("rst_pulse", 32'(sync_pulse), 32'd0);
        check("rst_terr", 32'(timeout_err), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_rstsync", 32'(rst_sync), 32'd0);
        check("rst_both_fsm", 32'(both_fsm), 32'd0);
        reset = 1'b0;
        tick(2);

        // One-shot arm and capture
        link_valid = 1'b1;
        channel_enable = 2'b11;
        pulse_sync();
        check("armed_fsm", 32'(fsm_state), 32'd1);
        check("armed_status", 32'(status), 32'd1);
        check("armed_rstsync", 32'(rst_sync), 32'd1);
        check("armed_valid", 32'(adc_valid), 32'd0);
        set_ext(1'b1);
        tick(2);
        check("pre_edge_fsm", 32'(fsm_state), 32'd1);
        tick();
        check("done_fsm", 32'(fsm_state), 32'd3);
        check("done_evc", 32'(evc), 32'd1);
        check("done_valid", 32'(adc_valid), 32'd3);
        check("done_status", 32'(status), 32'd0);

        // Edge while DONE only pulses
        set_ext(1'b0);
        tick(3);
        set_ext(1'b1);
        tick(5);
        check("done_edge_fsm", 32'(fsm_state), 32'd3);
        check("done_edge_evc", 32'(evc), 32'd1);

        pulse_sync();
        check("rearm_fsm", 32'(fsm_state), 32'd1);
        pulse_sync();
        check("sync_ignored", 32'(fsm_state), 32'd1);
        set_ext(1'b0);
        tick(3);

        // Disarm coincident with edge
        set_ext(1'b1);
        tick(2);
        adc_sync_disarm = 1'b1;
        tick();
        adc_sync_disarm = 1'b0;
        check("disarm_fsm", 32'(fsm_state), 32'd0);
        check("disarm_evc", 32'(evc), 32'd1);
        check("disarm_pulse", 32'(sync_pulse), 32'd1);
        check("disarm_status", 32'(status), 32'd0);

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].armed && fsm_state != 2'd1) pulse_sync();
            if (!vecs[i].armed && fsm_state == 2'd1) pulse_disarm();
            link_valid = vecs[i].link;
            channel_enable = vecs[i].en;
            #1;
            check($sformatf("adc_valid_vec%0d", i), 32'(adc_valid),
                  32'(vecs[i].exp));
            tick();
        end
        pulse_disarm();
        set_ext(1'b0);
        tick(4);

        // Continuous period measurement
        do_reset();
        tick();
        sync_mode = 1'b1;
        pulse_sync();
        for (int k = 0; k < 4; k++) begin
            set_ext(1'b1);
            if (k > 0) period_q.push_back(100);
            tick(50);
            set_ext(1'b0);
            tick(50);
        end
        tick(5);
        check("meas_fsm", 32'(fsm_state), 32'd2);
        check("meas_evc", 32'(evc), 32'd4);
        check("meas_period", period_count, 32'd100);
        check("sat_period", 32'(sat_period_count), 32'd15);
        check("sat_evc", 32'(sat_evc), 32'd4);
        check("sat_fsm", 32'(sat_fsm), 32'd2);

        // Both-edge period over a 20-cycle high pulse
        do_reset();
        tick();
        sync_mode = 1'b1;
        pulse_sync();
        both_stamps.delete();
        set_ext(1'b1);
        tick(20);
        set_ext(1'b0);
        tick(6);
        check("both_period", both_period_count, 32'd20);
        check("both_evc", 32'(both_evc), 32'd2);
        check("both_fsm", 32'(both_fsm), 32'd2);
        check("both_npulse", 32'(both_stamps.size()), 32'd2);
        if (both_stamps.size() >= 2)
            check("both_gap", 32'(both_stamps[1] - both_stamps[0]), 32'd20);
        check("rise_only_evc", 32'(evc), 32'd1);

        // Reset in the middle of a measurement
        tick(10);
        do_reset();
        check("midrst_fsm", 32'(both_fsm), 32'd0);
        check("midrst_period", both_period_count, 32'd0);
        check("midrst_pvalid", 32'(both_period_valid), 32'd0);
        tick(5);
        check("midrst_period2", both_period_count, 32'd0);

        // Timeout
        sync_mode = 1'b0;
        timeout_limit = 24'd50;
        pulse_sync();
        tick(49);
        check("to_armed_fsm", 32'(fsm_state), 32'd1);
        check("to_armed_err", 32'(timeout_err), 32'd0);
        tick();
`ifdef ADC_SYNC_TIMEOUT_EN
        check("to_fsm", 32'(fsm_state), 32'd0);
        check("to_err", 32'(timeout_err), 32'd1);
        pulse_sync();
        check("to_clr_err", 32'(timeout_err), 32'd0);
        check("to_clr_fsm", 32'(fsm_state), 32'd1);
`else
        check("noto_fsm", 32'(fsm_state), 32'd1);
        check("noto_err", 32'(timeout_err), 32'd0);
`endif
        timeout_limit = '0;
        pulse_disarm();
        tick(5);

        check("pulse_q_empty", 32'(pulse_q.size()), 32'd0);
        check("period_q_empty", 32'(period_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
